// File: rtl/fp_pkg.sv
// Shared constants, FIFO entry layout and state type for the float accumulator.
package fp_pkg;

   localparam int FP_W   = 32;
   localparam int EXP_W  = 8;
   localparam int MANT_W = 23;
   localparam logic [FP_W-1:0]  FP_ZERO      = '0;
   localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

   typedef struct packed {
      logic [FP_W-1:0] data;
      logic            sub;
      logic            last;
   } fp_entry_t;

   typedef enum logic {ACC, OUT} acc_state_t;

   // {nan, inf, zero}; the sign bit never matters, so it is not passed in.
   function automatic logic [2:0] fp_classify(input logic [FP_W-2:0] v);
      logic [EXP_W-1:0]  ex;
      logic [MANT_W-1:0] mn;
      ex = v[FP_W-2 -: EXP_W];
      mn = v[MANT_W-1:0];
      return {(ex == EXP_ALL_ONES) && (mn != '0),
              (ex == EXP_ALL_ONES) && (mn == '0),
              (ex == '0) && (mn == '0)};
   endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Input element stream and result stream of the float accumulator.
interface fp_accumulator_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_sub;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic [2:0]       out_flags;

   modport master (
      output in_valid, in_data, in_sub, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_flags
   );

   modport slave (
      input  in_valid, in_data, in_sub, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_flags
   );
endinterface

// File: rtl/floating_unit.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// full subnormal support, quiet NaN 7FC00000 for invalid operations.
module floating_unit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] result
);

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   logic        sb_eff, a_big, sx, sy;
   logic        a_nan, b_nan, a_inf, b_inf, rnd;
   logic [7:0]  ex, ey, exeff, eyeff, d, lz_ext, sh, exm1;
   logic [4:0]  dcap;
   logic [23:0] mx, my;
   logic [53:0] t;
   logic [26:0] ys, m;
   logic [27:0] s;
   logic [9:0]  e;
   logic [30:0] mag;

   always_comb begin
      sb_eff = b[31] ^ sub;
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_big  = a[30:0] >= b[30:0];

      // x is always the operand of larger magnitude
      if (a_big) begin
         sx = a[31];  ex = a[30:23]; mx = {|a[30:23], a[22:0]};
         sy = sb_eff; ey = b[30:23]; my = {|b[30:23], b[22:0]};
      end else begin
         sx = sb_eff; ex = b[30:23]; mx = {|b[30:23], b[22:0]};
         sy = a[31];  ey = a[30:23]; my = {|a[30:23], a[22:0]};
      end
      exeff = (ex == 8'd0) ? 8'd1 : ex;
      eyeff = (ey == 8'd0) ? 8'd1 : ey;
      d     = exeff - eyeff;
      dcap  = (d > 8'd30) ? 5'd30 : d[4:0];

      // Align y with guard/round/sticky; everything shifted out folds into sticky.
      t  = {my, 30'd0} >> dcap;
      ys = {t[53:28], t[27] | (|t[26:0])};

      if (sx == sy) s = {1'b0, mx, 3'b000} + {1'b0, ys};
      else          s = {1'b0, mx, 3'b000} - {1'b0, ys};

      lz_ext = {3'b000, lzc27(s[26:0])};
      exm1   = exeff - 8'd1;
      sh     = 8'd0;
      if (s[27]) begin
         m = {s[27:2], s[1] | s[0]};
         e = {2'b00, exeff} + 10'd1;
      end else begin
         // Never normalise below exponent 1; what remains is a subnormal.
         sh = (lz_ext > exm1) ? exm1 : lz_ext;
         m  = s[26:0] << sh;
         e  = {2'b00, exeff - sh};
      end

      rnd = m[2] & (m[1] | m[0] | m[3]);
      // A rounding carry ripples into the exponent field, covering subnormal->normal and overflow to Inf.
      mag = {(m[26] ? e[7:0] : 8'd0), m[25:3]} + {30'd0, rnd};

      result = {sx, mag};
      if (e >= 10'd255) result = {sx, 8'hFF, 23'd0};
      if (s == 28'd0)   result = {sx & sy, 31'd0};

      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != sb_eff))) result = 32'h7FC0_0000;
      else if (a_inf)                                               result = a;
      else if (b_inf)                                               result = {sb_eff, 8'hFF, 23'd0};
   end

endmodule

// File: rtl/fp_stream_fifo.sv
// Synchronous FIFO of accumulator entries: async reset, sync flush, no bypass.
module fp_stream_fifo
   import fp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      push,
   input  fp_entry_t din,
   input  logic      pop,
   output fp_entry_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   fp_entry_t   mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        do_push, do_pop;

   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/fp_accumulator.sv
// Streams float elements through a FIFO and folds them into a running sum with
// one floating_unit; emits sum, count and class flags on each last-tagged element.
module fp_accumulator
   import fp_pkg::*;
#(
   parameter int WIDTH      = FP_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   fp_accumulator_if.slave   bus
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   fp_entry_t        in_entry, head;
   logic             fifo_full, fifo_empty, push, pop;
   acc_state_t       state, state_nx;
   logic [WIDTH-1:0] acc, fu_sum, sum_q;
   logic [CNT_W-1:0] count, count_nx, count_q;

   assign in_entry     = '{data: bus.in_data, sub: bus.in_sub, last: bus.in_last};
   assign bus.in_ready = !fifo_full;
   assign push         = bus.in_valid && !fifo_full;
   assign count_nx     = sat_inc(count);

   fp_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clr),
      .push  (push),
      .din   (in_entry),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   floating_unit u_fu (
      .a      (acc),
      .b      (head.data),
      .sub    (head.sub),
      .result (fu_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      state <= ACC;
      else if (clr) state <= ACC;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ACC:     if (!fifo_empty && head.last) state_nx = OUT;
         OUT:     if (bus.out_ready)            state_nx = ACC;
         default: state_nx = ACC;
      endcase
   end

   always_comb begin
      pop           = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         ACC:     pop           = !fifo_empty;
         OUT:     bus.out_valid = 1'b1;
         default: pop           = 1'b0;
      endcase
   end

   // Fold stage: the popped head is combined with acc; a last element also publishes the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= FP_ZERO;
         count   <= '0;
         sum_q   <= FP_ZERO;
         count_q <= '0;
      end else if (clr) begin
         acc   <= FP_ZERO;
         count <= '0;
      end else if (pop) begin
         if (head.last) begin
            sum_q   <= fu_sum;
            count_q <= count_nx;
            acc     <= FP_ZERO;
            count   <= '0;
         end else begin
            acc   <= fu_sum;
            count <= count_nx;
         end
      end
   end

   assign bus.out_sum   = sum_q;
   assign bus.out_count = count_q;
   assign bus.out_flags = fp_classify(sum_q[WIDTH-2:0]);

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: directed vectors plus randomized
// integer-valued groups checked against an exact-arithmetic reference.
module tb_fp_accumulator;

   logic clk = 1'b0;
   logic rst;
   logic clr;
   int   n_checks = 0;
   int   n_errors = 0;

   fp_accumulator_if #(.WIDTH(32), .CNT_W(16)) bus ();

   fp_accumulator #(.WIDTH(32), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Exact float encoding of an integer with magnitude below 2^24.
   function automatic logic [31:0] i2f(input int v);
      logic [31:0] mag;
      int          msb;
      if (v == 0) return 32'h0;
      mag = (v < 0) ? 32'(-v) : 32'(v);
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      return {(v < 0), 8'(127 + msb), 23'((mag << (23 - msb)) & 32'h007F_FFFF)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_elem(input logic [31:0] d, input logic s, input logic l);
      int w = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sub   = s;
      bus.in_last  = l;
      while (!bus.in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) check("push_rdy", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_vld(input string tag);
      int w = 0;
      while (!bus.out_valid && w < 100) begin tick(); w++; end
      check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
   endtask

   task automatic wait_result(input string tag, input logic [31:0] es, input logic [15:0] ec,
                              input logic [2:0] ef, input int hold);
      bus.out_ready = 1'b0;
      wait_vld(tag);
      check({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
      check({tag, "_cnt"}, 64'(bus.out_count), 64'(ec));
      check({tag, "_flg"}, 64'(bus.out_flags), 64'(ef));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
         check({tag, "_hold_sum"}, 64'(bus.out_sum), 64'(es));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_ack"}, 64'(bus.out_valid), 64'd0);
   endtask

   task automatic run_pair(input string tag, input logic [31:0] d0, input logic s0,
                           input logic [31:0] d1, input logic s1,
                           input logic [31:0] es, input logic [2:0] ef);
      bus.out_ready = 1'b1;
      push_elem(d0, s0, 1'b0);
      push_elem(d1, s1, 1'b1);
      check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
      tick();
      check({tag, "_lat2"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
      check({tag, "_cnt"}, 64'(bus.out_count), 64'd2);
      check({tag, "_flg"}, 64'(bus.out_flags), 64'(ef));
      tick();
      check({tag, "_done"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      int k, w, total, n, v;
      logic s, acc_now;

      rst = 1'b1; clr = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sub = 1'b0; bus.in_last = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_sum", 64'(bus.out_sum), 64'd0);
      check("rst_out_count", 64'(bus.out_count), 64'd0);
      check("rst_out_flags", 64'(bus.out_flags), 64'b001);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      run_pair("add2",  32'h3FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 1'b0, 32'h407F_FFFF, 3'b000);
      run_pair("sub2",  32'h3FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 1'b1, 32'h0000_0000, 3'b001);
      run_pair("subn",  32'h0000_02CA, 1'b0, 32'h0000_02CA, 1'b0, 32'h0000_0594, 3'b000);
      run_pair("inf",   32'h7F80_0000, 1'b0, 32'h42F6_0000, 1'b0, 32'h7F80_0000, 3'b010);
      push_elem(32'h3F80_0000, 1'b0, 1'b1);
      wait_result("follow", 32'h3F80_0000, 16'd1, 3'b000, 0);

      // Backpressure: result held, FIFO fills to exactly four entries.
      push_elem(32'h3F80_0000, 1'b0, 1'b1);
      bus.out_ready = 1'b0;
      wait_vld("bp_first");
      k = 0;
      for (int c = 0; c < 10; c++) begin
         bus.in_valid = (k < 6); bus.in_data = i2f(k + 1); bus.in_sub = 1'b0; bus.in_last = (k == 5);
         acc_now = bus.in_valid && bus.in_ready;
         tick();
         if (acc_now) k++;
      end
      check("bp_accepted", 64'(k), 64'd4);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_hold_sum", 64'(bus.out_sum), 64'h3F80_0000);
      check("bp_hold_cnt", 64'(bus.out_count), 64'd1);
      bus.out_ready = 1'b1;
      w = 0;
      while (k < 6 && w < 50) begin
         bus.in_valid = 1'b1; bus.in_data = i2f(k + 1); bus.in_sub = 1'b0; bus.in_last = (k == 5);
         acc_now = bus.in_ready;
         tick();
         if (acc_now) k++;
         w++;
      end
      bus.in_valid = 1'b0;
      check("bp_drain", 64'(k), 64'd6);
      wait_result("bp_sum", i2f(21), 16'd6, 3'b000, 1);

      // Flush with three entries queued and a push offered in the same cycle.
      push_elem(i2f(7), 1'b0, 1'b1);
      wait_vld("clr_pre");
      push_elem(i2f(1), 1'b0, 1'b0);
      push_elem(i2f(2), 1'b0, 1'b0);
      push_elem(i2f(3), 1'b0, 1'b0);
      bus.in_valid = 1'b1; bus.in_data = i2f(100); bus.in_sub = 1'b0; bus.in_last = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0; bus.in_valid = 1'b0;
      check("clr_out_valid", 64'(bus.out_valid), 64'd0);
      check("clr_in_ready", 64'(bus.in_ready), 64'd1);
      check("clr_keep_sum", 64'(bus.out_sum), 64'(i2f(7)));
      check("clr_keep_cnt", 64'(bus.out_count), 64'd1);
      push_elem(32'h3F80_0000, 1'b0, 1'b1);
      wait_result("clr_after", 32'h3F80_0000, 16'd1, 3'b000, 0);

      // Randomized integer-valued groups: exact in single precision, so the
      // reference is plain integer addition re-encoded as a float.
      for (int g = 0; g < 25; g++) begin
         n = int'($urandom_range(1, 6));
         total = 0;
         for (int j = 0; j < n; j++) begin
            v = int'($urandom_range(0, 2000)) - 1000;
            s = 1'($urandom_range(0, 1));
            total += s ? -v : v;
            push_elem(i2f(v), s, (j == n - 1));
            repeat ($urandom_range(0, 1)) tick();
         end
         wait_result("rand", i2f(total), 16'(n), (total == 0) ? 3'b001 : 3'b000,
                     int'($urandom_range(0, 2)));
      end

      // Asynchronous reset while a result is held and the FIFO is full.
      push_elem(i2f(7), 1'b0, 1'b1);
      wait_vld("rst_pre");
      for (int j = 0; j < 4; j++) push_elem(i2f(j + 1), 1'b0, 1'b0);
      check("rst_pre_full", 64'(bus.in_ready), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_in_ready", 64'(bus.in_ready), 64'd1);
      check("arst_out_valid", 64'(bus.out_valid), 64'd0);
      check("arst_out_sum", 64'(bus.out_sum), 64'd0);
      check("arst_out_count", 64'(bus.out_count), 64'd0);
      check("arst_out_flags", 64'(bus.out_flags), 64'b001);
      tick();
      rst = 1'b0;
      tick();
      push_elem(32'h3F80_0000, 1'b0, 1'b1);
      wait_result("post_rst", 32'h3F80_0000, 16'd1, 3'b000, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
